// File: rtl/mem_wb_stage.sv
// mem_wb_stage: reusable inter-stage pipeline register with valid/ready
// handshake, synchronous flush, bubble-control injection and an optional
// 2-entry skid buffer. First used between MEM and WB.
//
// Handshake: an entry moves upstream->stage when in_valid && in_ready and
// stage->downstream when out_valid && out_ready, both on the rising clk edge.
// in_valid/in_data/in_ctrl are expected stable while waiting; the stage keeps
// out_data/out_ctrl stable while out_valid && !out_ready.
module mem_wb_stage #(
    parameter int                 DATA_W      = 96,
    parameter int                 CTRL_W      = 7,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
    parameter bit                 SKID        = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [15:0]       stall_cnt
);

    // Occupancy doubles as the FSM state so it can be observed directly.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              state_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   main_data_q;
    logic [CTRL_W-1:0]   main_ctrl_q;
    logic [DATA_W-1:0]   skid_data_q;
    logic [CTRL_W-1:0]   skid_ctrl_q;
    logic                in_ready_q;
    logic [15:0]         stall_q;
    logic [15:0]         stall_d;

    logic accept;
    logic consume;

    // Flush forces in_ready high for that cycle: the offered entry is dropped
    // rather than held upstream, so the producer can move on after a redirect.
    assign in_ready = SKID ? (in_ready_q | flush)
                           : ((state_q == ST_EMPTY) | out_ready | flush);

    assign accept  = in_valid & in_ready & ~flush;
    assign consume = out_valid_q & out_ready;

    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

    // Entry FSM: main register is always the head; skid holds the second entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            main_data_q <= '0;
            main_ctrl_q <= CTRL_BUBBLE;
            skid_data_q <= '0;
            skid_ctrl_q <= CTRL_BUBBLE;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            main_data_q <= '0;
            main_ctrl_q <= CTRL_BUBBLE;
            skid_data_q <= '0;
            skid_ctrl_q <= CTRL_BUBBLE;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_data_q <= in_data;
                        main_ctrl_q <= in_ctrl;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_data_q <= in_data;
                        main_ctrl_q <= in_ctrl;
                    end else if (accept) begin
                        // Only reachable with the skid buffer present.
                        if (SKID) begin
                            skid_data_q <= in_data;
                            skid_ctrl_q <= in_ctrl;
                            state_q     <= ST_TWO;
                            in_ready_q  <= 1'b0;
                        end
                    end else if (consume) begin
                        main_data_q <= '0;
                        main_ctrl_q <= CTRL_BUBBLE;
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        main_data_q <= skid_data_q;
                        main_ctrl_q <= skid_ctrl_q;
                        skid_data_q <= '0;
                        skid_ctrl_q <= CTRL_BUBBLE;
                        state_q     <= ST_ONE;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    out_valid_q <= 1'b0;
                    main_data_q <= '0;
                    main_ctrl_q <= CTRL_BUBBLE;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    // Next stall count: saturating increment while the head is blocked.
    always_comb begin
        stall_d = stall_q;
        if (out_valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage: one instance with the skid buffer and
// one without, each task checking its own scenario with hand-derived values.
module tb_mem_wb_stage;

    localparam int DATA_W = 96;
    localparam int CTRL_W = 7;
    localparam logic [CTRL_W-1:0] BUB = 7'd0;

    logic              clk;
    logic              reset;
    logic              flush;

    // SKID=1 instance signals
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
    logic [15:0]       stall_cnt;

    // SKID=0 instance signals
    logic              in_valid0;
    logic              in_ready0;
    logic [DATA_W-1:0] in_data0;
    logic [CTRL_W-1:0] in_ctrl0;
    logic              out_valid0;
    logic              out_ready0;
    logic [DATA_W-1:0] out_data0;
    logic [CTRL_W-1:0] out_ctrl0;
    logic [1:0]        occupancy0;
    logic [15:0]       stall_cnt0;
    logic              flush0;

    int total;
    int bad;

    mem_wb_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(BUB), .SKID(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    mem_wb_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(BUB), .SKID(1'b0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_ctrl(in_ctrl0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_ctrl(out_ctrl0),
        .occupancy(occupancy0), .stall_cnt(stall_cnt0)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] pat;
        pat = {12{8'hA5}};
        reset = 1'b0; flush = 1'b0; flush0 = 1'b0;
        in_valid = 1'b1; in_data = pat; in_ctrl = 7'h55; out_ready = 1'b0;
        in_valid0 = 1'b1; in_data0 = pat; in_ctrl0 = 7'h55; out_ready0 = 1'b0;
        tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        total++; if (out_ctrl !== BUB) begin bad++; $display("FAIL reset_out_ctrl got=%0h exp=%0h", out_ctrl, BUB); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL reset_in_ready0 got=%0b exp=1", in_ready0); end
        total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL reset_out_valid0 got=%0b exp=0", out_valid0); end
        in_valid = 1'b0; in_valid0 = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_ctrl  = 7'(i);
            in_data  = DATA_W'(i * 16'h1111);
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%0b exp=1", i, out_valid); end
            total++; if (out_ctrl !== 7'(i)) begin bad++; $display("FAIL stream_ctrl[%0d] got=%0d exp=%0d", i, out_ctrl, i); end
            total++; if (out_data !== DATA_W'(i * 16'h1111)) begin bad++; $display("FAIL stream_data[%0d] got=%0h exp=%0h", i, out_data, i * 16'h1111); end
            total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, occupancy); end
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain_valid got=%0b exp=0", out_valid); end
        total++; if (out_ctrl !== BUB) begin bad++; $display("FAIL stream_drain_ctrl got=%0h exp=%0h", out_ctrl, BUB); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL stream_drain_occ got=%0d exp=0", occupancy); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL stream_stall got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_back_pressure();
        // A accepted; from here out_ready stays low until released.
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 7'h0A; in_data = 96'hA;
        tick();
        total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL bp_occ_a got=%0d exp=1", occupancy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_a got=%0b exp=1", in_ready); end
        in_ctrl = 7'h0B; in_data = 96'hB;
        tick();
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL bp_occ_b got=%0d exp=2", occupancy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_b got=%0b exp=0", in_ready); end
        total++; if (out_ctrl !== 7'h0A) begin bad++; $display("FAIL bp_head_b got=%0h exp=a", out_ctrl); end
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL bp_stall_b got=%0d exp=1", stall_cnt); end
        in_ctrl = 7'h0C; in_data = 96'hC;
        tick();
        tick();
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL bp_occ_hold got=%0d exp=2", occupancy); end
        total++; if (out_ctrl !== 7'h0A) begin bad++; $display("FAIL bp_head_hold got=%0h exp=a", out_ctrl); end
        total++; if (out_data !== 96'hA) begin bad++; $display("FAIL bp_data_hold got=%0h exp=a", out_data); end
        total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL bp_stall_hold got=%0d exp=3", stall_cnt); end
        out_ready = 1'b1;
        tick();
        total++; if (out_ctrl !== 7'h0B) begin bad++; $display("FAIL bp_out_b got=%0h exp=b", out_ctrl); end
        total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL bp_occ_rel got=%0d exp=1", occupancy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_rel got=%0b exp=1", in_ready); end
        tick();
        total++; if (out_ctrl !== 7'h0C) begin bad++; $display("FAIL bp_out_c got=%0h exp=c", out_ctrl); end
        total++; if (out_data !== 96'hC) begin bad++; $display("FAIL bp_data_c got=%0h exp=c", out_data); end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
        total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL bp_stall_final got=%0d exp=3", stall_cnt); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 7'h0D; in_data = 96'hD;
        tick();
        in_ctrl = 7'h0E; in_data = 96'hE;
        tick();
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=2", occupancy); end
        // Offer F together with flush; it must be dropped.
        in_ctrl = 7'h0F; in_data = 96'hF; flush = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
        total++; if (out_ctrl !== BUB) begin bad++; $display("FAIL flush_ctrl got=%0h exp=%0h", out_ctrl, BUB); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL flush_data got=%0h exp=0", out_data); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
        total++; if (stall_cnt !== 16'd5) begin bad++; $display("FAIL flush_stall got=%0d exp=5", stall_cnt); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped[%0d] got=%0b exp=0 ctrl=%0h", i, out_valid, out_ctrl); end
        end
    endtask

    task automatic test_skid0();
        out_ready0 = 1'b0;
        in_valid0 = 1'b1; in_ctrl0 = 7'h21; in_data0 = 96'h1234_5678;
        tick();
        total++; if (occupancy0 !== 2'd1) begin bad++; $display("FAIL s0_occ got=%0d exp=1", occupancy0); end
        total++; if (in_ready0 !== 1'b0) begin bad++; $display("FAIL s0_ready_blocked got=%0b exp=0", in_ready0); end
        total++; if (out_data0 !== 96'h1234_5678) begin bad++; $display("FAIL s0_data_p got=%0h exp=12345678", out_data0); end
        out_ready0 = 1'b1; in_ctrl0 = 7'h22; in_data0 = 96'hDEAD_BEEF;
        #1;
        total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL s0_ready_comb got=%0b exp=1", in_ready0); end
        tick();
        total++; if (out_data0 !== 96'hDEAD_BEEF) begin bad++; $display("FAIL s0_reload_data got=%0h exp=deadbeef", out_data0); end
        total++; if (out_ctrl0 !== 7'h22) begin bad++; $display("FAIL s0_reload_ctrl got=%0h exp=22", out_ctrl0); end
        total++; if (occupancy0 !== 2'd1) begin bad++; $display("FAIL s0_reload_occ got=%0d exp=1", occupancy0); end
        in_valid0 = 1'b0;
        tick();
        total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL s0_drain_valid got=%0b exp=0", out_valid0); end
        total++; if (out_data0 !== '0) begin bad++; $display("FAIL s0_drain_data got=%0h exp=0", out_data0); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 7'h33; in_data = 96'h33;
        tick();
        in_valid = 1'b0;
        // stall_cnt starts at 5 here; 70000 blocked cycles pass 16'hFFFF.
        repeat (70000) tick();
        total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_value got=%0h exp=ffff", stall_cnt); end
        repeat (3) tick();
        total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%0h exp=ffff", stall_cnt); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_flush got=%0h exp=ffff", stall_cnt); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sat_flush_valid got=%0b exp=0", out_valid); end
        reset = 1'b0;
        tick();
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL sat_reset got=%0h exp=0", stall_cnt); end
        reset = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_skid0();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised inter-stage pipeline register for the RISC-V pipeline, generalising the fixed MEM/WB latch into a reusable stage with valid/ready handshake, synchronous flush, bubble-control injection and an optional 2-entry skid buffer. It sits between any two pipeline stages, first instantiated between MEM and WB. It carries an opaque data payload and a control word. When no valid entry is held, the control word is forced to a parametrised bubble value, so downstream write enables stay safely gated.

## Interface
- DATA_W, 96: payload width (ALU/jump address, memory data, immediate).
- CTRL_W, 7: control word width (rd, EscReg, lw).
- CTRL_BUBBLE, 0: control word driven when out_valid=0, and after reset or flush.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk.
- flush  in  1  drop all held entries (hazard/branch redirect).
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage accepts an entry this cycle.
- in_data  in  DATA_W  payload.
- in_ctrl  in  CTRL_W  control word.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream consumes the entry this cycle.
- out_data  out  DATA_W  payload; zero when out_valid=0.
- out_ctrl  out  CTRL_W  control word; CTRL_BUBBLE when out_valid=0.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).
- stall_cnt  out  16  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Accept: in_valid && in_ready. Consume: out_valid && out_ready.
- SKID=1 state machine (occupancy encodes the state):
  - EMPTY: accept → ONE.
  - ONE: accept without consume → TWO. Consume without accept → EMPTY. Both → ONE (main register reloads).
  - TWO: in_ready=0. Consume → ONE, with the skid entry moving to the main register.
- Output order is strict FIFO. The skid entry is never presented before the main entry.
- in_ready (SKID=1) is a flop: 1 in EMPTY and ONE, 0 in TWO. It does not depend combinationally on out_ready.
- SKID=0: in_ready = (occupancy==0) || out_ready. Accept with a simultaneous consume reloads the register.
- flush (reset inactive): occupancy→0, out_valid→0, out_data→0, out_ctrl→CTRL_BUBBLE. An input offered in the same cycle is dropped, and in_ready reads 1 in that cycle. Flush has priority over accept and consume.
- reset=0: every output takes its reset value. reset has priority over flush. A reset asserted with two entries held discards both.
- stall_cnt: increments by 1 in each cycle where out_valid && !out_ready, saturates at 16'hFFFF, and is cleared only by reset. Flush does not clear it.
- Reset values: out_valid 0, out_data 0, out_ctrl CTRL_BUBBLE, occupancy 0, stall_cnt 0, in_ready 1 (both SKID settings).

## Timing
- Latency: an entry accepted at edge N is on out_* after edge N, with out_valid=1 in cycle N+1.
- Throughput: 1 entry/cycle while out_ready=1.
- While out_valid && !out_ready, out_data and out_ctrl are stable.
- SKID=1: after out_ready drops, at most one further entry is accepted, then in_ready drops in the next cycle.
- All outputs are registered except in_ready when SKID=0.

## Test plan
- Reset: hold reset=0 for 2 cycles with in_valid=1 and in_data=0xA5.. → out_valid=0, out_ctrl=CTRL_BUBBLE, occupancy=0, stall_cnt=0, in_ready=1.
- Streaming: SKID=1, out_ready=1, feed ctrl 1,2,3,4 on consecutive cycles → out_ctrl 1,2,3,4 one cycle later, no bubbles, occupancy stays 1.
- Back-pressure: SKID=1, feed A,B,C with out_ready=0 from the cycle A appears → occupancy reaches 2, in_ready=0, C is held upstream. Raise out_ready → A, B, C emerge in order. stall_cnt equals the number of stalled cycles.
- Flush with TWO entries and a simultaneous in_valid → next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, occupancy=0. The dropped input never appears on the output.
- SKID=0: occupancy=1 with out_ready=0 → in_ready=0 in the same cycle. With out_ready=1 and in_valid=1, out_data changes to the new payload at the next edge.
- Saturation: hold out_valid=1 and out_ready=0 for 70000 cycles → stall_cnt=16'hFFFF and stays there. A following flush leaves it unchanged; reset=0 clears it to 0.
